// File: rtl/dft_pkg.sv
// Shared types and helpers for the DFT sweep sequencer.
package dft_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RESTART,
        RUN,
        EMIT
    } sweep_state_t;

    // Index width for an N-point transform; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dft_sweep_collect.sv
// Sequences the DFT core through every component index, captures each result
// and emits it as an indexed valid/ready stream; a watchdog catches a silent core.
module dft_sweep_collect
    import dft_pkg::*;
#(
    parameter int WIDTH   = 24,
    parameter int SAMPLES = 4,
    parameter int IDXW    = idx_width(SAMPLES),
    parameter int TIMEOUT = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic                    core_reset,
    output logic [IDXW-1:0]         core_idx,
    input  logic                    core_ready,
    input  logic signed [WIDTH-1:0] core_real,
    input  logic signed [WIDTH-1:0] core_imag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IDXW-1:0]         out_idx,
    output logic signed [WIDTH-1:0] out_real,
    output logic signed [WIDTH-1:0] out_imag,
    output logic                    out_last
);

    typedef logic signed [WIDTH-1:0] comp_t;

    localparam int CNTW = $clog2(TIMEOUT) + 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SAMPLES - 1);
    // Timeout fires on the edge where the counter would reach TIMEOUT-1.
    localparam logic [CNTW-1:0] CNT_LIMIT = CNTW'(TIMEOUT - 2);

    sweep_state_t    state, state_nxt;
    logic [IDXW-1:0] idx, idx_nxt;
    logic [CNTW-1:0] cnt, cnt_nxt;
    logic            done_nxt, error_nxt, valid_nxt, last_nxt;
    logic [IDXW-1:0] oidx_nxt;
    comp_t           re_nxt, im_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        error_nxt = error;
        valid_nxt = out_valid;
        oidx_nxt  = out_idx;
        re_nxt    = out_real;
        im_nxt    = out_imag;
        last_nxt  = out_last;

        if (abort) begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx_nxt   = '0;
                        error_nxt = 1'b0;
                        state_nxt = RESTART;
                    end
                end
                RESTART: begin
                    cnt_nxt   = '0;
                    state_nxt = RUN;
                end
                RUN: begin
                    cnt_nxt = cnt + CNTW'(1);
                    // A ready in the first RUN cycle may be left over from the previous component.
                    if (core_ready && (cnt != '0)) begin
                        re_nxt    = core_real;
                        im_nxt    = core_imag;
                        oidx_nxt  = idx;
                        last_nxt  = (idx == LAST_IDX);
                        valid_nxt = 1'b1;
                        state_nxt = EMIT;
                    end else if (cnt == CNT_LIMIT) begin
                        error_nxt = 1'b1;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                EMIT: begin
                    if (out_valid && out_ready) begin
                        valid_nxt = 1'b0;
                        if (out_last) begin
                            done_nxt  = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            idx_nxt   = idx + IDXW'(1);
                            state_nxt = RESTART;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx        <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            core_reset <= 1'b1;
            core_idx   <= '0;
            out_valid  <= 1'b0;
            out_idx    <= '0;
            out_real   <= '0;
            out_imag   <= '0;
            out_last   <= 1'b0;
        end else begin
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            busy       <= (state_nxt != IDLE);
            done       <= done_nxt;
            error      <= error_nxt;
            // The core only runs while we are waiting on it; everywhere else it is held.
            core_reset <= (state_nxt != RUN);
            core_idx   <= idx_nxt;
            out_valid  <= valid_nxt;
            out_idx    <= oidx_nxt;
            out_real   <= re_nxt;
            out_imag   <= im_nxt;
            out_last   <= last_nxt;
        end
    end

endmodule
